im_load_ctrl: RTL and testbench
===============================

# im_load_ctrl

Boot-load controller and port arbiter for the 16-word instruction memory.
- After reset it holds the core out of fetch.
- It accepts a program stream over a valid/ready handshake and writes the words sequentially into IM.
- It reads every written word back, checks the sum against a host-supplied checksum, then hands the IM port to the fetch PC and releases the core.
- It sits between the host loader, the IM port (memWrite, memRead, pc, dataIn, IR) and the core's PC register.

## Interface
- DEPTH, 16, number of IM words; also the maximum word_count
- AW, 4, word-index width, equal to log2(DEPTH)
- DW, 32, instruction width
- clk  in  1  single clock; IM captures writes on the negedge of the same clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse that latches word_count and expected_sum and begins a load
- word_count  in  AW+1  number of words to load; legal range 1..DEPTH
- expected_sum  in  DW  mod-2^32 sum of all program words
- in_valid  in  1  stream word valid
- in_data  in  DW  stream word
- in_ready  out  1  equals (state==LOAD)
- fetch_pc  in  32  core PC; passed to the IM port only in RUN
- im_memWrite  out  1  IM write enable
- im_memRead  out  1  IM read enable
- im_pc  out  32  IM byte address
- im_dataIn  out  DW  IM write data
- im_IR  in  DW  IM read data; combinational from im_pc
- run  out  1  core fetch enable
- done  out  1  one-cycle pulse on entry to RUN
- error  out  1  high in ERROR
- err_code  out  2  0 none, 1 bad word_count, 2 checksum mismatch

## Operation
States: IDLE, LOAD, DRAIN, VERIFY, CMP, RUN, ERROR.
- **IDLE:**
  - start with word_count in 1..DEPTH -> LOAD; latch count and expected_sum; clear idx and sum.
  - start with word_count 0 or >DEPTH -> ERROR, err_code=1.
- **LOAD:**
  - Each edge with in_valid&in_ready registers a write for the next cycle: im_memWrite=1, im_pc={idx,2'b00}, im_dataIn=in_data; then idx++.
  - Accepting word count-1 -> DRAIN.
  - Stalls on in_valid are unbounded.
- **DRAIN:**
  - One cycle; the last write is on the port.
  - Then -> VERIFY with idx=0.
- **VERIFY:**
  - im_memRead=1, im_pc={idx,2'b00}, im_memWrite=0.
  - Each edge: sum += im_IR (mod 2^32), idx++.
  - After idx=count-1 -> CMP.
- **CMP:**
  - sum==expected_sum -> RUN; otherwise -> ERROR with err_code=2.
- **RUN:**
  - run=1, im_pc=fetch_pc, im_memRead=1, im_memWrite=0.
  - done=1 in the first RUN cycle only.
- **Port default:** outside RUN, im_pc is driven by the controller.
  - im_memWrite is 1 only in the cycle after an accept.
  - im_memRead is 1 only in VERIFY and RUN.
- **start in RUN or ERROR:** restarts as from IDLE; run drops, err_code clears. start in LOAD, DRAIN, VERIFY or CMP is ignored.
- **in_valid outside LOAD:** ignored; in_ready=0.

## Timing
- **Reset values:**
  - state=IDLE.
  - run, done, error, im_memWrite, im_memRead = 0.
  - err_code=0, im_pc=0, im_dataIn=0, in_ready=0.
- **Reset mid-operation:** same values on the next edge; partially loaded words are discarded. IM reset reloads its init contents.
- **Write timing:** write outputs are registered on the posedge and the IM captures them on the following negedge. The readback address therefore never coincides with a pending write.
- **Latency:** start sampled at edge E0 with in_valid held high:
  - Words are accepted at E1..EN.
  - The controller is in DRAIN after EN and in VERIFY after EN+1.
  - Read samples occur at EN+2..E2N+1.
  - The controller is in CMP after E2N+1; run and done rise after E2N+2, i.e. 2N+2 cycles after start.
- **N=16:** 34 cycles.
- **Arithmetic:** sum is DW bits wide and wraps; idx is AW bits. count=DEPTH ends at idx=DEPTH-1, so there is no wrap to 0.

## Structure
- **Package im_ctrl_pkg:**
  - state enum.
  - err_code constants ERR_NONE, ERR_COUNT, ERR_SUM.
  - DEPTH/AW/DW defaults.
  - localparam for the byte-address shift (2).
- **Sub-module im_port_mux:** selects fetch_pc vs the controller address and gates memWrite/memRead by state. All other logic lives in im_load_ctrl.

## Test plan
- **Minimal load:** start with count=1, expected_sum=32'h0000_1234, one word 32'h0000_1234.
  - im_memWrite pulses once at im_pc=0.
  - run=1 and done pulse 4 cycles after start.
  - err_code=0.
- **Full depth, in_valid held high:** count=16, words 32'h100+i.
  - Writes land at im_pc 0,4,..,60.
  - done occurs 34 cycles after start.
  - With run=1, im_pc follows fetch_pc=32'h8.
- **Backpressure:** in_valid toggles 1,0,0,1,... with count=4.
  - Only handshaken words are written, at consecutive addresses.
  - done is delayed exactly by the idle cycles.
- **Bad count:** count=0, then count=17.
  - ERROR the next cycle, err_code=1, in_ready never 1, no IM write.
- **Checksum fail:** count=2, words 1 and 2, expected_sum=4.
  - ERROR with err_code=2 and run=0.
  - A following start with expected_sum=3 recovers to RUN.
- **Reset mid-load:** assert reset after 3 of 8 words.
  - All outputs take their reset values next edge and in_ready=0.
  - A new start then completes normally.

Source files
------------

// File: rtl/im_load_ctrl_pkg.sv
// Shared constants for the instruction-memory boot loader: geometry, FSM
// state encodings, error codes and the word-to-byte address helper.
package im_ctrl_pkg;

    localparam int DEPTH      = 16;
    localparam int AW         = 4;
    localparam int DW         = 32;
    localparam int BYTE_SHIFT = 2;

    // Plain constants rather than an enum so older netlist tools see fixed codes.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_DRAIN  = 3'd2;
    localparam logic [2:0] ST_VERIFY = 3'd3;
    localparam logic [2:0] ST_CMP    = 3'd4;
    localparam logic [2:0] ST_RUN    = 3'd5;
    localparam logic [2:0] ST_ERROR  = 3'd6;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_COUNT = 2'd1;
    localparam logic [1:0] ERR_SUM   = 2'd2;

    function automatic logic [31:0] byte_addr(input logic [AW-1:0] idx);
        return 32'(idx) << BYTE_SHIFT;
    endfunction

endpackage

// File: rtl/im_load_ctrl_if.sv
// Program-stream handshake plus the instruction-memory port, bundled so the
// loader, the host and the IM model share one connection.
interface im_load_ctrl_if
    import im_ctrl_pkg::*;
;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;

    logic          im_memWrite;
    logic          im_memRead;
    logic [31:0]   im_pc;
    logic [DW-1:0] im_dataIn;
    logic [DW-1:0] im_IR;

    modport master (
        input  in_valid, in_data, im_IR,
        output in_ready, im_memWrite, im_memRead, im_pc, im_dataIn
    );

    modport slave (
        output in_valid, in_data, im_IR,
        input  in_ready, im_memWrite, im_memRead, im_pc, im_dataIn
    );

endinterface

// File: rtl/im_load_ctrl_port_mux.sv
// IM port arbitration: the core's fetch PC owns the address only in RUN,
// otherwise the loader drives it; enables are qualified by the loader state.
module im_port_mux
    import im_ctrl_pkg::*;
(
    input  logic [2:0]    state,
    input  logic [AW-1:0] ctrl_idx,
    input  logic          wr_pending,
    input  logic [31:0]   fetch_pc,
    output logic [31:0]   im_pc,
    output logic          im_memWrite,
    output logic          im_memRead
);

    always_comb begin
        im_pc       = (state == ST_RUN) ? fetch_pc : byte_addr(ctrl_idx);
        im_memWrite = wr_pending && ((state == ST_LOAD) || (state == ST_DRAIN));
        im_memRead  = (state == ST_VERIFY) || (state == ST_RUN);
    end

endmodule

// File: rtl/im_load_ctrl.sv
// Boot-load controller: streams a program into IM, reads it back to verify a
// checksum, then hands the IM port to the fetch PC and releases the core.
module im_load_ctrl
    import im_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [AW:0]           word_count,
    input  logic [DW-1:0]         expected_sum,
    input  logic [31:0]           fetch_pc,
    im_load_ctrl_if.master        bus,
    output logic                  run,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_code
);

    logic [2:0]    state;
    logic [AW-1:0] idx;
    logic [AW-1:0] wr_addr;
    logic [AW:0]   count;
    logic [DW-1:0] exp_sum;
    logic [DW-1:0] sum;
    logic [DW-1:0] wr_data;
    logic          wr_pending;
    logic          count_ok;
    logic          at_last;
    logic [AW-1:0] ctrl_idx;

    assign count_ok = (word_count != '0) && (word_count <= (AW+1)'(DEPTH));
    assign at_last  = ({1'b0, idx} == (count - (AW+1)'(1)));

    // Writes are registered and land in IM on the following negedge, so the
    // write address is held separately from the running index.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            idx        <= '0;
            wr_addr    <= '0;
            count      <= '0;
            exp_sum    <= '0;
            sum        <= '0;
            wr_data    <= '0;
            wr_pending <= 1'b0;
            done       <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            wr_pending <= 1'b0;
            done       <= 1'b0;
            case (state)
                ST_IDLE, ST_RUN, ST_ERROR: begin
                    if (start) begin
                        idx <= '0;
                        sum <= '0;
                        if (count_ok) begin
                            state    <= ST_LOAD;
                            count    <= word_count;
                            exp_sum  <= expected_sum;
                            err_code <= ERR_NONE;
                        end else begin
                            state    <= ST_ERROR;
                            err_code <= ERR_COUNT;
                        end
                    end
                end
                ST_LOAD: begin
                    if (bus.in_valid) begin
                        wr_pending <= 1'b1;
                        wr_addr    <= idx;
                        wr_data    <= bus.in_data;
                        idx        <= idx + AW'(1);
                        if (at_last) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    idx   <= '0;
                    state <= ST_VERIFY;
                end
                ST_VERIFY: begin
                    sum <= sum + bus.im_IR;
                    idx <= idx + AW'(1);
                    if (at_last) begin
                        state <= ST_CMP;
                    end
                end
                ST_CMP: begin
                    if (sum == exp_sum) begin
                        state <= ST_RUN;
                        done  <= 1'b1;
                    end else begin
                        state    <= ST_ERROR;
                        err_code <= ERR_SUM;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign ctrl_idx     = (state == ST_VERIFY) ? idx : wr_addr;
    assign bus.in_ready = (state == ST_LOAD);
    assign bus.im_dataIn = wr_data;
    assign run          = (state == ST_RUN);
    assign error        = (state == ST_ERROR);

    im_port_mux u_port_mux (
        .state       (state),
        .ctrl_idx    (ctrl_idx),
        .wr_pending  (wr_pending),
        .fetch_pc    (fetch_pc),
        .im_pc       (bus.im_pc),
        .im_memWrite (bus.im_memWrite),
        .im_memRead  (bus.im_memRead)
    );

endmodule

// File: tb/tb_im_load_ctrl.sv
// Directed bench for im_load_ctrl: a table of load scenarios against a small
// IM model, plus reset checks and a reset in the middle of a load.
module tb_im_load_ctrl;
    import im_ctrl_pkg::*;

    typedef struct {
        logic [AW:0]   count;
        logic [DW-1:0] base;
        logic [DW-1:0] exp_sum;
        logic [3:0]    pattern;
        logic [1:0]    exp_err;
        int            exp_edges;
    } vec_t;

    typedef struct {
        logic [31:0]   addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW:0]   word_count;
    logic [DW-1:0] expected_sum;
    logic [31:0]   fetch_pc;
    logic          run;
    logic          done;
    logic          error;
    logic [1:0]    err_code;

    logic [DW-1:0] mem [DEPTH];
    wr_t           wr_log[$];
    vec_t          vecs[9];
    int            checks = 0;
    int            errors = 0;

    im_load_ctrl_if bus();

    im_load_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .word_count   (word_count),
        .expected_sum (expected_sum),
        .fetch_pc     (fetch_pc),
        .bus          (bus),
        .run          (run),
        .done         (done),
        .error        (error),
        .err_code     (err_code)
    );

    always #5 clk = ~clk;

    // IM model: combinational read, write captured on the negedge.
    assign bus.im_IR = mem[bus.im_pc[5:2]];

    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hDEAD_0000 + 32'(i);
        end else if (bus.im_memWrite) begin
            mem[bus.im_pc[5:2]] <= bus.im_dataIn;
            wr_log.push_back('{bus.im_pc, bus.im_dataIn});
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".run"},       32'(run), 32'd0);
        checkOutput({tag, ".done"},      32'(done), 32'd0);
        checkOutput({tag, ".error"},     32'(error), 32'd0);
        checkOutput({tag, ".memWrite"},  32'(bus.im_memWrite), 32'd0);
        checkOutput({tag, ".memRead"},   32'(bus.im_memRead), 32'd0);
        checkOutput({tag, ".err_code"},  32'(err_code), 32'd0);
        checkOutput({tag, ".im_pc"},     bus.im_pc, 32'd0);
        checkOutput({tag, ".im_dataIn"}, bus.im_dataIn, 32'd0);
        checkOutput({tag, ".in_ready"},  32'(bus.in_ready), 32'd0);
    endtask

    // Pulse start, feed the stream per the valid pattern, then check the
    // outcome, edge count after start, and every IM write that happened.
    task automatic applyStimulus(input vec_t v, input string tag);
        int sent = 0;
        int seen = -1;
        int nwr;
        bit hs = 1'b0;
        bit saw_ready = 1'b0;
        wr_log.delete();
        word_count   = v.count;
        expected_sum = v.exp_sum;
        start        = 1'b1;
        for (int c = 1; c <= 100 && seen < 0; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (hs) sent++;
            if (bus.in_ready) saw_ready = 1'b1;
            if (done || error) seen = c - 1;
            bus.in_valid = (sent < int'(v.count)) && v.pattern[(c - 1) % 4];
            bus.in_data  = v.base + DW'(sent);
            hs = bus.in_valid && bus.in_ready;
        end
        bus.in_valid = 1'b0;

        checkOutput({tag, ".edges"},    32'(seen), 32'(v.exp_edges));
        checkOutput({tag, ".err_code"}, 32'(err_code), 32'(v.exp_err));
        checkOutput({tag, ".run"},      32'(run), 32'(v.exp_err == ERR_NONE));
        checkOutput({tag, ".error"},    32'(error), 32'(v.exp_err != ERR_NONE));
        checkOutput({tag, ".ready_seen"}, 32'(saw_ready), 32'(v.exp_err != ERR_COUNT));

        nwr = (v.exp_err == ERR_COUNT) ? 0 : int'(v.count);
        checkOutput({tag, ".writes"}, 32'(wr_log.size()), 32'(nwr));
        for (int i = 0; i < nwr && i < wr_log.size(); i++) begin
            checkOutput($sformatf("%s.wr%0d_addr", tag, i), wr_log[i].addr, 32'(i * 4));
            checkOutput($sformatf("%s.wr%0d_data", tag, i), wr_log[i].data, v.base + DW'(i));
        end

        if (v.exp_err == ERR_NONE) begin
            fetch_pc = 32'h8;
            #1;
            checkOutput({tag, ".fetch_pc"}, bus.im_pc, 32'h8);
            checkOutput({tag, ".run_read"}, 32'(bus.im_memRead), 32'd1);
            checkOutput({tag, ".run_write"}, 32'(bus.im_memWrite), 32'd0);
            @(negedge clk);
            checkOutput({tag, ".done_pulse"}, 32'(done), 32'd0);
            checkOutput({tag, ".run_held"}, 32'(run), 32'd1);
        end
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        word_count   = '0;
        expected_sum = '0;
        fetch_pc     = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        // count, base word, expected_sum, valid pattern (bit0 first), error, edges to done/error
        vecs[0] = '{5'd1,  32'h0000_1234, 32'h0000_1234, 4'b1111, ERR_NONE,  4};
        vecs[1] = '{5'd16, 32'h0000_0100, 32'h0000_1078, 4'b1111, ERR_NONE,  34};
        vecs[2] = '{5'd4,  32'hA000_0000, 32'h8000_0006, 4'b1001, ERR_NONE,  14};
        vecs[3] = '{5'd3,  32'h0000_0010, 32'h0000_0033, 4'b0101, ERR_NONE,  10};
        vecs[4] = '{5'd0,  32'h0000_0000, 32'h0000_0000, 4'b1111, ERR_COUNT, 0};
        vecs[5] = '{5'd17, 32'h0000_0000, 32'h0000_0000, 4'b1111, ERR_COUNT, 0};
        vecs[6] = '{5'd2,  32'h0000_0001, 32'h0000_0004, 4'b1111, ERR_SUM,   6};
        vecs[7] = '{5'd2,  32'h0000_0001, 32'h0000_0003, 4'b1111, ERR_NONE,  6};
        vecs[8] = '{5'd2,  32'h0000_0007, 32'h0000_000F, 4'b0110, ERR_NONE,  7};

        repeat (3) @(negedge clk);
        checkResetState("reset");
        reset = 1'b0;
        @(negedge clk);

        for (int r = 0; r < 8; r++) begin
            applyStimulus(vecs[r], $sformatf("vec%0d", r));
        end

        // Reset after three of eight words have been accepted.
        word_count   = 5'd8;
        expected_sum = '0;
        start        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h55;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("midload.in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("midload.memWrite", 32'(bus.im_memWrite), 32'd1);
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkResetState("midreset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        applyStimulus(vecs[8], "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
